// File: rtl/fsm_control_param_if.sv
// Control/status bundle between software-facing control and the FIFO supervisor.
// master drives requests and FIFO flags; slave returns thresholds and status.
interface fsm_control_param_if #(
  parameter int NUM_FIFOS = 5,
  parameter int TH_W      = 4
);
  logic                      init;
  logic [NUM_FIFOS*TH_W-1:0] umbral_in;
  logic [NUM_FIFOS-1:0]      fifo_error;
  logic [NUM_FIFOS-1:0]      fifo_empty;
  logic                      error_clear;
  logic [NUM_FIFOS*TH_W-1:0] umbral_out;
  logic                      active;
  logic                      idle;
  logic [NUM_FIFOS-1:0]      error;
  logic [2:0]                state;

  modport master (
    output init, umbral_in, fifo_error, fifo_empty, error_clear,
    input  umbral_out, active, idle, error, state
  );

  modport slave (
    input  init, umbral_in, fifo_error, fifo_empty, error_clear,
    output umbral_out, active, idle, error, state
  );
endinterface

// File: rtl/fsm_control_param.sv
// N-FIFO flow-control supervisor: threshold capture, idle/active status, sticky errors.
// Moore outputs, all registered: every status change appears one edge after the causing input.
module fsm_control_param #(
  parameter int NUM_FIFOS   = 5,
  parameter int TH_W        = 4,
  parameter int IDLE_CYCLES = 3
) (
  input logic                 clk,
  input logic                 reset,
  fsm_control_param_if.slave  ctrl
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_e;

  localparam int UW = NUM_FIFOS * TH_W;
  localparam int EW = (IDLE_CYCLES < 1) ? 1 : $clog2(IDLE_CYCLES + 1);
  localparam logic [EW-1:0] ECNT_LAST = EW'(IDLE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [EW-1:0]        ecnt_q, ecnt_d;
  logic [UW-1:0]        umbral_q, umbral_d;
  logic [NUM_FIFOS-1:0] error_q, error_d;
  logic                 idle_q, active_q;

  logic any_err;
  logic all_empty;

  assign any_err   = |ctrl.fifo_error;
  assign all_empty = &ctrl.fifo_empty;

  // Priority in every non-RESET state: error, then init, then the local condition.
  always_comb begin
    state_d  = state_q;
    ecnt_d   = '0;
    umbral_d = umbral_q;
    error_d  = error_q;
    unique case (state_q)
      S_RESET: begin
        state_d = S_INIT;
      end
      S_INIT: begin
        umbral_d = ctrl.umbral_in;
        if (any_err) begin
          state_d = S_ERROR;
          error_d = ctrl.fifo_error;
        end else if (!ctrl.init) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (any_err) begin
          state_d = S_ERROR;
          error_d = ctrl.fifo_error;
        end else if (ctrl.init) begin
          state_d = S_INIT;
        end else if (!all_empty) begin
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (any_err) begin
          state_d = S_ERROR;
          error_d = ctrl.fifo_error;
        end else if (ctrl.init) begin
          state_d = S_INIT;
        end else if (all_empty) begin
          if (ecnt_q == ECNT_LAST) begin
            state_d = S_IDLE;
          end else begin
            ecnt_d = ecnt_q + EW'(1);
          end
        end
      end
      S_ERROR: begin
        // A clear wins over errors arriving on the same edge.
        if (ctrl.error_clear) begin
          state_d = S_IDLE;
          error_d = '0;
        end else begin
          error_d = error_q | ctrl.fifo_error;
        end
      end
      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_RESET;
      ecnt_q   <= '0;
      umbral_q <= '0;
      error_q  <= '0;
      idle_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ecnt_q   <= ecnt_d;
      umbral_q <= umbral_d;
      error_q  <= error_d;
      idle_q   <= (state_d == S_IDLE);
      active_q <= (state_d == S_ACTIVE);
    end
  end

  assign ctrl.state      = state_q;
  assign ctrl.idle       = idle_q;
  assign ctrl.active     = active_q;
  assign ctrl.error      = error_q;
  assign ctrl.umbral_out = umbral_q;

endmodule

// File: tb/tb_fsm_control_param.sv
// Bench for fsm_control_param: vector table fed through an expected-result queue,
// plus hand-written sequences for asynchronous reset and error-from-INIT.
module tb_fsm_control_param;

  logic clk;
  logic reset;

  fsm_control_param_if #(.NUM_FIFOS(5), .TH_W(4)) bus ();

  fsm_control_param #(.NUM_FIFOS(5), .TH_W(4), .IDLE_CYCLES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        init;
    logic [4:0]  ferr;
    logic [4:0]  fempty;
    logic        eclr;
    logic [19:0] umb;
    logic [2:0]  st;
    logic [19:0] umb_o;
    logic [4:0]  err;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_chk;
  int   n_pass;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic add(input logic i, input logic [4:0] fe, input logic [4:0] em, input logic c,
                     input logic [19:0] u, input logic [2:0] s, input logic [19:0] uo, input logic [4:0] e);
    vec_t v;
    v.init = i; v.ferr = fe; v.fempty = em; v.eclr = c; v.umb = u;
    v.st = s; v.umb_o = uo; v.err = e;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    bus.init        = v.init;
    bus.fifo_error  = v.ferr;
    bus.fifo_empty  = v.fempty;
    bus.error_clear = v.eclr;
    bus.umbral_in   = v.umb;
  endtask

  task automatic check_outputs(input string tag, input int idx, input logic [2:0] st,
                               input logic [19:0] uo, input logic [4:0] err);
    chk({tag, ".state"},  idx, 32'(bus.state), 32'(st));
    chk({tag, ".idle"},   idx, 32'(bus.idle), 32'(st == 3'd2));
    chk({tag, ".active"}, idx, 32'(bus.active), 32'(st == 3'd3));
    chk({tag, ".umbral"}, idx, 32'(bus.umbral_out), 32'(uo));
    chk({tag, ".error"},  idx, 32'(bus.error), 32'(err));
  endtask

  initial begin
    vec_t v;
    vec_t e;
    n_chk  = 0;
    n_pass = 0;

    // init, ferr, fempty, eclr, umbral_in  ->  state, umbral_out, error
    add(1, 5'h00, 5'h1f, 0, 20'h12345, 3'd1, 20'h00000, 5'h00); // RESET -> INIT
    add(1, 5'h00, 5'h1f, 0, 20'h12345, 3'd1, 20'h12345, 5'h00);
    add(1, 5'h00, 5'h1f, 0, 20'h12345, 3'd1, 20'h12345, 5'h00);
    add(0, 5'h00, 5'h1f, 0, 20'h12345, 3'd2, 20'h12345, 5'h00); // init falls -> IDLE
    add(0, 5'h00, 5'h1f, 0, 20'habcde, 3'd2, 20'h12345, 5'h00); // thresholds frozen outside INIT
    add(0, 5'h00, 5'h1e, 0, 20'habcde, 3'd3, 20'h12345, 5'h00); // IDLE -> ACTIVE
    add(0, 5'h00, 5'h1f, 0, 20'habcde, 3'd3, 20'h12345, 5'h00);
    add(0, 5'h00, 5'h1f, 0, 20'habcde, 3'd3, 20'h12345, 5'h00);
    add(0, 5'h00, 5'h1d, 0, 20'habcde, 3'd3, 20'h12345, 5'h00); // count restart
    add(0, 5'h00, 5'h1f, 0, 20'habcde, 3'd3, 20'h12345, 5'h00);
    add(0, 5'h00, 5'h1f, 0, 20'habcde, 3'd3, 20'h12345, 5'h00);
    add(0, 5'h00, 5'h1f, 0, 20'habcde, 3'd2, 20'h12345, 5'h00); // third empty edge -> IDLE
    add(0, 5'h00, 5'h1e, 1, 20'habcde, 3'd3, 20'h12345, 5'h00); // clear outside ERROR ignored
    add(0, 5'h04, 5'h1e, 0, 20'habcde, 3'd4, 20'h12345, 5'h04); // sticky error capture
    add(0, 5'h10, 5'h1e, 0, 20'habcde, 3'd4, 20'h12345, 5'h14);
    add(0, 5'h00, 5'h1e, 0, 20'habcde, 3'd4, 20'h12345, 5'h14);
    add(1, 5'h00, 5'h1e, 0, 20'habcde, 3'd4, 20'h12345, 5'h14); // init ignored in ERROR
    add(1, 5'h00, 5'h1e, 0, 20'habcde, 3'd4, 20'h12345, 5'h14);
    add(0, 5'h01, 5'h1f, 1, 20'habcde, 3'd2, 20'h12345, 5'h00); // clear beats new error
    add(1, 5'h08, 5'h1f, 0, 20'habcde, 3'd4, 20'h12345, 5'h08); // error beats init
    add(0, 5'h00, 5'h1f, 1, 20'habcde, 3'd2, 20'h12345, 5'h00);
    add(1, 5'h00, 5'h1f, 0, 20'habcde, 3'd1, 20'h12345, 5'h00); // IDLE -> INIT
    add(0, 5'h00, 5'h1f, 0, 20'habcde, 3'd2, 20'habcde, 5'h00); // loaded on exit edge
    add(0, 5'h00, 5'h1e, 0, 20'h00000, 3'd3, 20'habcde, 5'h00);
    add(0, 5'h00, 5'h1f, 0, 20'h00000, 3'd3, 20'habcde, 5'h00);
    add(0, 5'h00, 5'h1f, 0, 20'h00000, 3'd3, 20'habcde, 5'h00); // ecnt now 2

    reset = 1'b0;
    v = tbl[0];
    drive(v);
    #2;
    check_outputs("rst", -1, 3'd0, 20'h0, 5'h0);
    @(posedge clk); #1;
    check_outputs("rst_edge", -1, 3'd0, 20'h0, 5'h0);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      exp_q.push_back(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      check_outputs("vec", i, e.st, e.umb_o, e.err);
    end

    // Asynchronous reset dropped mid-ACTIVE, between edges.
    chk("ecnt_before_reset", -1, 32'(dut.ecnt_q), 32'd2);
    #2 reset = 1'b0;
    #1;
    check_outputs("async_rst", -1, 3'd0, 20'h0, 5'h0);
    chk("async_rst.ecnt", -1, 32'(dut.ecnt_q), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    v.init = 1'b1; v.ferr = 5'h00; v.fempty = 5'h1f; v.eclr = 1'b0; v.umb = 20'h55555;
    drive(v);
    @(posedge clk); #1;
    check_outputs("post_rst", -1, 3'd1, 20'h0, 5'h0);

    // Error while held in INIT still captures the threshold on that exit edge.
    v.ferr = 5'h02;
    drive(v);
    @(posedge clk); #1;
    check_outputs("init_err", -1, 3'd4, 20'h55555, 5'h02);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fsm_control_param.md
# fsm_control_param

Parametrised flow-control supervisor for the N-FIFO datapath. It captures per-FIFO thresholds during initialisation and drives the registered `idle`/`active` status. It also latches FIFO errors until software clears them. It generalises the fixed 5-FIFO control FSM with three additions: a configurable FIFO count and threshold width, an empty-debounce before returning to idle, and an error-clear path that avoids a full reset.

## Interface
- NUM_FIFOS, 5, number of supervised FIFOs (>=1)
- TH_W, 4, bit width of each per-FIFO threshold (>=1)
- IDLE_CYCLES, 3, consecutive all-empty clock edges required in ACTIVE before returning to IDLE (>=1)
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- init  input  1  request/hold initialisation (threshold load)
- umbral_in  input  NUM_FIFOS*TH_W  packed thresholds, FIFO i at bits [i*TH_W +: TH_W]
- fifo_error  input  NUM_FIFOS  per-FIFO error flags (level)
- fifo_empty  input  NUM_FIFOS  per-FIFO empty flags
- error_clear  input  1  clears latched errors, leaves ERROR
- umbral_out  output  NUM_FIFOS*TH_W  registered thresholds, same packing
- active  output  1  high while in ACTIVE
- idle  output  1  high while in IDLE
- error  output  NUM_FIFOS  sticky per-FIFO error bits
- state  output  3  encoded state: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4

## Operation
- States: RESET, INIT, IDLE, ACTIVE, ERROR.
- Transitions in every non-RESET state use this priority: error > init > local condition.

Per-state behaviour:
- **RESET**
  - Entered asynchronously whenever `reset`=0.
  - First rising edge with `reset`=1 goes to INIT unconditionally.
- **INIT**
  - `umbral_out` <= `umbral_in` on every edge while in INIT, including the exit edge.
  - |`fifo_error` goes to ERROR.
  - Else `init`=0 goes to IDLE.
  - Else stays in INIT.
- **IDLE**
  - |`fifo_error` goes to ERROR.
  - Else `init`=1 goes to INIT.
  - Else `fifo_empty` != all-ones goes to ACTIVE.
  - Else stays in IDLE.
- **ACTIVE**
  - |`fifo_error` goes to ERROR.
  - Else `init`=1 goes to INIT.
  - Else uses empty counter `ecnt`, width clog2(IDLE_CYCLES+1):
    - If &`fifo_empty`: when `ecnt`==IDLE_CYCLES-1, go to IDLE and zero `ecnt`; otherwise `ecnt`++.
    - If not all empty: `ecnt` <= 0.
  - `ecnt` is zeroed on every edge in any state other than ACTIVE.
- **ERROR**
  - `error` <= `error` | `fifo_error` on every edge, so new error bits accumulate.
  - `error_clear`=1 goes to IDLE with `error` <= 0 on the same edge. A simultaneous `fifo_error` is discarded.
  - `init` is ignored in ERROR.

Other rules:
- On the edge that enters ERROR, `error` <= `fifo_error`, so bits are captured that cycle.
- `error_clear` outside ERROR has no effect.
- Thresholds are never modified outside INIT. Values are stored unmodified; all TH_W-bit values are legal.

## Timing
- Moore outputs. `idle`, `active` and `state` are registered and reflect the current state. They change one edge after the causing input is sampled.
- Values while `reset`=0: `state`=0, `idle`=0, `active`=0, `error`=0, `umbral_out`=0, `ecnt`=0.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- After reset release, INIT is reached on the first edge. Thresholds are visible on `umbral_out` one edge after sampling.
- Minimum ACTIVE-to-IDLE latency is IDLE_CYCLES edges of continuous all-empty. A single non-empty edge restarts the count.
- IDLE to ACTIVE takes 1 edge.
- Any state to ERROR takes 1 edge.
- ERROR to IDLE takes 1 edge after `error_clear`.

## Test plan
- **Reset and load** (NUM_FIFOS=5, TH_W=4)
  - Stimulus: hold `reset`=0, release; `init`=1 with `umbral_in`=20'h1_2345 for 3 edges, then `init`=0.
  - Required: all outputs 0 during reset; `state`=1 after the first edge; `umbral_out`=20'h1_2345; `idle`=1 one edge after `init` falls.
- **Empty debounce** (IDLE_CYCLES=3)
  - Stimulus: from IDLE, `fifo_empty`=5'b11110 for 1 edge, then 5'b11111 for 2 edges, 5'b11101 for 1 edge, then 5'b11111 for 3 edges.
  - Required: ACTIVE after the first edge; stays ACTIVE through the 2-edge empty run; `idle`=1 exactly on the third edge of the final empty run.
- **Sticky error**
  - Stimulus: in ACTIVE, `fifo_error`=5'b00100 for 1 edge, then 5'b10000 for 1 edge, then 0.
  - Required: `state`=4 and `error`=5'b00100 after the first edge; `error`=5'b10100 after the second; holds 5'b10100 afterwards; `active`=0.
- **Error clear and priority**
  - Stimulus: in ERROR, `init`=1 for 2 edges; then `error_clear`=1 together with `fifo_error`=5'b00001.
  - Required: stays in ERROR while only `init` is high; on the clear edge `state`=2 and `error`=0.
- **Error beats init**
  - Stimulus: in IDLE, `init`=1 and `fifo_error`=5'b01000 on the same edge.
  - Required: `state`=4, `umbral_out` unchanged.
- **Asynchronous reset mid-ACTIVE**
  - Stimulus: drop `reset` between clock edges with `ecnt`=2.
  - Required: all outputs and `ecnt` go to 0 before the next edge; the first edge after release gives `state`=1.
